// File: rtl/opb_register_simulink2ppc_snap_if.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_snap_if
//
// OPB slave-side bundle for the Simulink-to-PPC snapshot register.
// Bit numbering follows the OPB convention: index 0 is the MSB.
//
//   OPB_ABus    [0:31]  address from the master
//   OPB_BE      [0:3]   byte enables, BE[3] covers DBus[24:31]
//   OPB_DBus    [0:31]  write data from the master
//   OPB_RNW             1 = read, 0 = write
//   OPB_select          transaction qualifier
//   OPB_seqAddr         sequential address hint (not used by the slave)
//   Sl_DBus     [0:31]  read data from the slave, zero outside the ack cycle
//   Sl_xferAck          one-cycle transfer acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup   always 0 from this slave
// ---------------------------------------------------------------------------
interface opb_register_simulink2ppc_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_snap
//
// OPB slave that captures a 32-bit fabric word and returns it to the PowerPC.
// Captures are free-running (mode 0, latest word wins) or armed one-shot
// snapshots (mode 1). Every capture sets a valid flag; loads that overwrite
// an unread word set a sticky overflow flag and bump a saturating counter.
//
// Ports:
//   OPB_Clk        sole clock, fabric side is synchronous to it
//   OPB_Rst_n      asynchronous active-low reset
//   opb            OPB slave bundle (see opb_register_simulink2ppc_snap_if)
//   user_data_in   fabric word to capture
//   user_valid     capture strobe
//   user_captured  mirrors the valid flag
//
// Register map (word offsets within a 256-byte window):
//   0x00 DATA    RO  held word; an acked read clears valid
//   0x04 STATUS  RO  [31] valid [30] overflow [29] armed [28] mode [15:0] count
//   0x08 CTRL    WO  DBus[31] clear, DBus[30] arm, DBus[29] mode (needs BE[3]);
//                    reads return mode at DBus[29], i.e. the same bit lane
//                    that writes it, so a CTRL readback reads 0x4 in mode 1
//   others       reads 0, writes acked and ignored
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                                   OPB_Clk,
  input  logic                                   OPB_Rst_n,
  opb_register_simulink2ppc_snap_if.slave        opb,
  input  logic [31:0]                            user_data_in,
  input  logic                                   user_valid,
  output logic                                   user_captured
);

  localparam logic [5:0] OFF_DATA   = 6'd0;
  localparam logic [5:0] OFF_STATUS = 6'd1;
  localparam logic [5:0] OFF_CTRL   = 6'd2;

  // The family string only documents the target; no family-specific
  // primitives are used, so the block below is intentionally empty.
  if (C_FAMILY == "") begin : g_no_family
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [C_OPB_DWIDTH-1:0] data_reg,    data_next;
  logic                    valid_reg,   valid_next;
  logic                    ovf_reg,     ovf_next;
  logic [15:0]             ovf_cnt_reg, ovf_cnt_next;
  logic                    armed_reg,   armed_next;
  logic                    mode_reg,    mode_next;
  logic                    ack_reg,     ack_next;
  logic [C_OPB_DWIDTH-1:0] rdata_reg,   rdata_next;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [5:0]              offset;
  logic                    addr_hit;
  logic                    fire;

  // ABus[0:31] maps onto addr[31:0] value-for-value; ABus[24:29] is the
  // word offset, which is addr[7:2] in descending numbering.
  assign addr     = opb.OPB_ABus;
  assign offset   = addr[7:2];
  assign addr_hit = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // ack_reg is high during the ack cycle; it blocks a second ack while the
  // master still holds select in that cycle.
  assign fire     = addr_hit && !ack_reg;

  // ---------------------------------------------------------------------
  // Transaction qualifiers
  // ---------------------------------------------------------------------
  logic wr_ctrl;
  logic ctrl_clear;
  logic ctrl_arm;
  logic ctrl_mode;
  logic data_read;
  logic capture_req;
  logic capture;

  assign wr_ctrl     = fire && !opb.OPB_RNW && (offset == OFF_CTRL) && opb.OPB_BE[3];
  assign ctrl_clear  = wr_ctrl && opb.OPB_DBus[31];
  assign ctrl_arm    = wr_ctrl && opb.OPB_DBus[30];
  assign ctrl_mode   = opb.OPB_DBus[29];
  assign data_read   = fire && opb.OPB_RNW && (offset == OFF_DATA);

  // In one-shot mode only an armed block accepts a word.
  assign capture_req = user_valid && (!mode_reg || armed_reg);
  // A load coinciding with a clear write is dropped.
  assign capture     = capture_req && !ctrl_clear;

  // ---------------------------------------------------------------------
  // Capture / control next state
  // ---------------------------------------------------------------------
  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    ovf_next     = ovf_reg;
    ovf_cnt_next = ovf_cnt_reg;
    armed_next   = armed_reg;
    mode_next    = mode_reg;

    if (capture) begin
      data_next  = user_data_in;
      valid_next = 1'b1;
      // Overwriting an unread word is an overflow, unless the processor is
      // reading DATA in this same cycle: that word has been consumed.
      if (valid_reg && !data_read) begin
        ovf_next = 1'b1;
        if (ovf_cnt_reg != 16'hFFFF) begin
          ovf_cnt_next = ovf_cnt_reg + 16'd1;
        end
      end
      if (mode_reg) begin
        armed_next = 1'b0;
      end
    end else if (data_read) begin
      valid_next = 1'b0;
    end

    // Clear keeps data and mode; arm applied after clear re-arms cleanly.
    if (ctrl_clear) begin
      valid_next   = 1'b0;
      ovf_next     = 1'b0;
      ovf_cnt_next = 16'd0;
      armed_next   = 1'b0;
    end
    if (ctrl_arm) begin
      armed_next = 1'b1;
      valid_next = 1'b0;
    end
    if (wr_ctrl) begin
      mode_next = ctrl_mode;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------
  logic [C_OPB_DWIDTH-1:0] read_mux;

  always_comb begin
    read_mux = '0;
    case (offset)
      OFF_DATA:   read_mux = data_reg;
      OFF_STATUS: read_mux = {valid_reg, ovf_reg, armed_reg, mode_reg, 12'h000, ovf_cnt_reg};
      OFF_CTRL:   read_mux = {29'd0, mode_reg, 2'b00};
      default:    read_mux = '0;
    endcase
  end

  always_comb begin
    ack_next   = fire;
    rdata_next = (fire && opb.OPB_RNW) ? read_mux : '0;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      ovf_cnt_reg <= 16'd0;
      armed_reg   <= 1'b0;
      mode_reg    <= 1'b0;
      ack_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ovf_reg     <= ovf_next;
      ovf_cnt_reg <= ovf_cnt_next;
      armed_reg   <= armed_next;
      mode_reg    <= mode_next;
      ack_reg     <= ack_next;
      rdata_reg   <= rdata_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign opb.Sl_DBus    = rdata_reg;
  assign opb.Sl_xferAck = ack_reg;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_captured  = valid_reg;

  // Inputs that carry no function in this slave.
  logic unused_bits;
  assign unused_bits = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:28]};

endmodule
